// File: rtl/count_snapshot_pkg.sv
// Shared widths, entry layout and sizing helper for the count_snapshot timestamping stage.
package count_snapshot_pkg;

    localparam int CNT_W_D   = 4;
    localparam int EPOCH_W_D = 8;
    localparam int DEPTH_D   = 4;

    // Level counter must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVL_W_D = lvl_w(DEPTH_D);

    typedef struct packed {
        logic [EPOCH_W_D-1:0] epoch;
        logic [CNT_W_D-1:0]   count;
    } snap_entry_t;

endpackage

// File: rtl/count_snapshot_if.sv
// Valid/ready snapshot drain port; master side produces snapshots, slave side consumes them.
interface count_snapshot_if #(
    parameter int DATA_W = 12
) ();
    logic              snap_valid;
    logic              snap_ready;
    logic [DATA_W-1:0] snap_data;

    modport master (output snap_valid, output snap_data, input snap_ready);
    modport slave  (input snap_valid, input snap_data, output snap_ready);
endinterface

// File: rtl/count_snapshot_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module count_snapshot_fifo #(
    parameter int  DATA_W = 12,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int LVL_W  = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              full_s;
    logic              empty_s;

    assign full_s  = (level_r == LVL_W'(DEPTH));
    assign empty_s = (level_r == {LVL_W{1'b0}});
    assign rd_en_s = pop && !empty_s;
    assign wr_en_s = push && (!full_s || rd_en_s);

    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;
    // Head is forced to zero when empty so stale storage never leaks out after a flush.
    assign dout  = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; reset flushes everything in one edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/count_snapshot.sv
// Timestamping stage behind the free-running counter: wrap detection, epoch extension, capture FIFO.
// Optional step checker compiled in with `define COUNT_SNAPSHOT_STEP_CHECK_EN.
module count_snapshot
    import count_snapshot_pkg::*;
#(
    parameter int  CNT_W   = CNT_W_D,
    parameter int  EPOCH_W = EPOCH_W_D,
    parameter int  DEPTH   = DEPTH_D,
    localparam int LVL_W   = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic             cap_req,
    count_snapshot_if.master snap,
    output logic             wrap,
    output logic             overflow,
    output logic             step_err,
    output logic [LVL_W-1:0] fifo_level
);

    logic [CNT_W-1:0]         count_q_r;
    logic                     prev_valid_r;
    logic [EPOCH_W-1:0]       epoch_r;
    logic                     wrap_r;
    logic                     overflow_r;
    logic                     wrap_det_s;
    logic [EPOCH_W-1:0]       epoch_next_s;
    logic                     full_s;
    logic                     empty_s;
    logic                     pop_s;
    logic                     drop_s;
    logic [EPOCH_W+CNT_W-1:0] head_s;

    assign wrap_det_s   = prev_valid_r && (count_q_r == {CNT_W{1'b1}}) && (count == {CNT_W{1'b0}});
    // A capture coinciding with a wrap is stamped with the post-wrap epoch.
    assign epoch_next_s = epoch_r + EPOCH_W'(wrap_det_s);
    assign pop_s        = !empty_s && snap.snap_ready;
    assign drop_s       = cap_req && full_s && !pop_s;

    count_snapshot_fifo #(
        .DATA_W (EPOCH_W + CNT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_req),
        .pop   (snap.snap_ready),
        .din   ({epoch_next_s, count}),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level),
        .dout  (head_s)
    );

    assign snap.snap_valid = !empty_s;
    assign snap.snap_data  = head_s;
    assign wrap            = wrap_r;
    assign overflow        = overflow_r;

    // Sample history, epoch extension, wrap pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q_r    <= {CNT_W{1'b0}};
            prev_valid_r <= 1'b0;
            epoch_r      <= {EPOCH_W{1'b0}};
            wrap_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            count_q_r    <= count;
            prev_valid_r <= 1'b1;
            epoch_r      <= epoch_next_s;
            wrap_r       <= wrap_det_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef COUNT_SNAPSHOT_STEP_CHECK_EN
    logic step_det_s;
    logic step_err_r;

    assign step_det_s = prev_valid_r && (count != (count_q_r + CNT_W'(1)));
    assign step_err   = step_err_r;

    // Sticky flag for any sample that did not advance by exactly one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            step_err_r <= 1'b0;
        end else if (step_det_s) begin
            step_err_r <= 1'b1;
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_snapshot.sv
// Self-checking bench for count_snapshot: directed vector table, hand-written corner sequences, random run vs. queue model.
module tb_count_snapshot;
    import count_snapshot_pkg::*;

`ifdef COUNT_SNAPSHOT_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] count;
    logic       cap_req;
    logic       wrap;
    logic       overflow;
    logic       step_err;
    logic [2:0] fifo_level;

    count_snapshot_if #(.DATA_W(12)) sif ();

    count_snapshot dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .cap_req    (cap_req),
        .snap       (sif),
        .wrap       (wrap),
        .overflow   (overflow),
        .step_err   (step_err),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: a plain queue of packed entries plus scalar bookkeeping.
    logic [11:0] m_q[$];
    int          m_epoch;
    int          m_prev;
    bit          m_pv;
    bit          m_wrap;
    bit          m_ovf;
    bit          m_step;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [3:0] c, input bit cap, input bit rdy);
        bit          wd;
        bit          popd;
        bit          was_full;
        int          e;
        snap_entry_t ent;
        if (!r) begin
            m_q.delete();
            m_epoch = 0; m_prev = 0; m_pv = 0;
            m_wrap = 0; m_ovf = 0; m_step = 0;
        end else begin
            wd       = m_pv && (m_prev == 15) && (c == 4'd0);
            e        = (m_epoch + (wd ? 1 : 0)) % 256;
            was_full = (m_q.size() == DEPTH_D);
            popd     = (m_q.size() > 0) && rdy;
            if (popd) void'(m_q.pop_front());
            if (cap) begin
                if (!was_full || popd) begin
                    ent.epoch = e[7:0];
                    ent.count = c;
                    m_q.push_back(ent);
                end else begin
                    m_ovf = 1;
                end
            end
            if (STEP_EN && m_pv && (int'(c) != (m_prev + 1) % 16)) m_step = 1;
            m_epoch = e;
            m_wrap  = wd;
            m_prev  = int'(c);
            m_pv    = 1;
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(sif.snap_valid), 32'(m_q.size() > 0));
        chk("m_data",  32'(sif.snap_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("m_level", 32'(fifo_level),     32'(m_q.size()));
        chk("m_wrap",  32'(wrap),           32'(m_wrap));
        chk("m_ovf",   32'(overflow),       32'(m_ovf));
        chk("m_step",  32'(step_err),       32'(m_step));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic apply(input bit r, input logic [3:0] c, input bit cap, input bit rdy);
        rst            = r;
        count          = c;
        cap_req        = cap;
        sif.snap_ready = rdy;
        @(posedge clk);
        model_edge(r, c, cap, rdy);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         r;
        logic [3:0] c;
        bit         cap;
        bit         rdy;
        bit         e_valid;
        logic [11:0] e_data;
        bit         e_wrap;
        bit         e_ovf;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int wraps;
        logic [3:0] c;
        rst = 1'b0; count = 4'd0; cap_req = 1'b0; sif.snap_ready = 1'b0;

        // r  cnt  cap rdy | valid data    wrap ovf lvl
        tbl.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1'b1, 4'd5,  1'b1, 1'b0, 1'b1, 12'h005, 1'b0, 1'b0, 3'd1});
        tbl.push_back('{1'b1, 4'd6,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1'b1, 4'd1,  1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 3'd1});
        tbl.push_back('{1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 3'd2});
        tbl.push_back('{1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 3'd3});
        tbl.push_back('{1'b1, 4'd4,  1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 3'd4});
        tbl.push_back('{1'b1, 4'd5,  1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1, 3'd4});
        tbl.push_back('{1'b1, 4'd6,  1'b0, 1'b1, 1'b1, 12'h002, 1'b0, 1'b1, 3'd3});
        tbl.push_back('{1'b1, 4'd7,  1'b0, 1'b1, 1'b1, 12'h003, 1'b0, 1'b1, 3'd2});
        tbl.push_back('{1'b1, 4'd8,  1'b0, 1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 3'd1});
        tbl.push_back('{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 3'd0});
        tbl.push_back('{1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 3'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].cap, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(sif.snap_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_data", i),  32'(sif.snap_data),  32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_wrap", i),  32'(wrap),           32'(tbl[i].e_wrap));
            chk($sformatf("tbl%0d_ovf", i),   32'(overflow),       32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level),     32'(tbl[i].e_lvl));
        end

        // Wrap with a capture on the zero sample, then a later capture in epoch 1.
        apply(1'b0, 4'd0, 1'b0, 1'b0);
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 4'(i), 1'b0, 1'b0);
            if (wrap) wraps++;
        end
        apply(1'b1, 4'd0, 1'b1, 1'b0);
        if (wrap) wraps++;
        chk("wrap_pulse",    32'(wrap),           32'd1);
        chk("wrap_cap_data", 32'(sif.snap_data),  32'h010);
        chk("wrap_cap_vld",  32'(sif.snap_valid), 32'd1);
        apply(1'b1, 4'd1, 1'b0, 1'b1);
        if (wrap) wraps++;
        chk("wrap_one_cyc", 32'(wrap), 32'd0);
        apply(1'b1, 4'd2, 1'b0, 1'b0);
        if (wrap) wraps++;
        apply(1'b1, 4'd3, 1'b1, 1'b0);
        if (wrap) wraps++;
        chk("wrap_count",   32'(wraps),          32'd1);
        chk("epoch1_data",  32'(sif.snap_data),  32'h013);

        // Step error: 3 -> 7 jump, sticky until reset.
        apply(1'b0, 4'd0, 1'b0, 1'b0);
        apply(1'b1, 4'd2, 1'b0, 1'b0);
        apply(1'b1, 4'd3, 1'b0, 1'b0);
        chk("step_before", 32'(step_err), 32'd0);
        apply(1'b1, 4'd7, 1'b0, 1'b0);
        chk("step_rise",   32'(step_err), 32'(STEP_EN));
        apply(1'b1, 4'd8, 1'b0, 1'b0);
        apply(1'b1, 4'd9, 1'b0, 1'b0);
        chk("step_sticky", 32'(step_err), 32'(STEP_EN));
        apply(1'b0, 4'd0, 1'b0, 1'b0);
        chk("step_clear",  32'(step_err), 32'd0);

        // Long clean run: enough wraps to roll the epoch past 255.
        c = 4'd0;
        for (int i = 0; i < 4300; i++) begin
            apply(1'b1, c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            c = c + 4'd1;
        end

        // Mixed run: occasional resets and count jumps.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 40) == 0) c = 4'($urandom_range(0, 15));
            else c = c + 4'd1;
            apply(($urandom_range(0, 199) != 0), c, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_snapshot.md
# count_snapshot

Downstream consumer of the free-running 4-bit `counter` output. Samples `count` every cycle, detects wrap-around, extends the count with an epoch (wrap) counter, and captures timestamped snapshots into a small FIFO on request. A valid/ready port drains the snapshots. The block is the timestamping stage behind the counter in the `counter` testbench environment.

## Interface
- `CNT_W`, 4: width of the upstream count.
- `EPOCH_W`, 8: width of the wrap (epoch) counter.
- `DEPTH`, 4: number of FIFO entries; must be a power of 2, at least 2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `count`  in  CNT_W  value from the upstream counter; increments by 1 per cycle.
- `cap_req`  in  1  capture strobe, sampled every cycle.
- `snap_valid`  out  1  FIFO head is valid.
- `snap_ready`  in  1  consumer accepts the head.
- `snap_data`  out  EPOCH_W+CNT_W  FIFO head, packed as {epoch, count}.
- `wrap`  out  1  one-cycle pulse per detected wrap.
- `overflow`  out  1  sticky; a capture was dropped because the FIFO was full.
- `step_err`  out  1  sticky; the count did not step by +1.
- `fifo_level`  out  clog2(DEPTH)+1  current number of entries.

## Operation
- `count_q` is a register that holds the previous sample of `count`. `prev_valid` is set on the first clock after reset is released.
- A wrap is detected when `wrap_det` = `prev_valid` && `count_q` is all-ones && `count` == 0.
- On `wrap_det`, the epoch increments modulo 2^EPOCH_W. Rolling over from 255 to 0 is silent.
- On a capture (`cap_req` high at an edge), the entry {epoch + `wrap_det`, `count`} is pushed. A capture in the same cycle as a wrap therefore carries the new epoch.
- The push succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle (`snap_valid` && `snap_ready`).
- If the FIFO is full and no pop happens, the entry is dropped and `overflow` is set.
- The FIFO is first-word-fall-through: `snap_valid` = !empty and `snap_data` = head. A pop happens on an edge where `snap_valid` && `snap_ready`.
- Push and pop on an empty FIFO: the push occurs and no pop occurs.
- `fifo_level` reports 0..DEPTH and changes by at most 1 per cycle. A simultaneous push and pop leaves it unchanged.
- Sticky flags clear only on reset.

## Timing
- While `rst` is low, on every edge:
  - `snap_valid`, `wrap`, `overflow`, `step_err` and `fifo_level` are all 0.
  - `snap_data` is 0.
  - Epoch, `count_q`, `prev_valid` and the FIFO pointers are cleared.
  - `cap_req` is ignored.
- Reset asserted mid-operation flushes all FIFO contents in one cycle. No partial state survives.
- Capture latency: with `cap_req` at edge N and the FIFO empty, `snap_valid` = 1 and `snap_data` are valid in cycle N+1.
- `wrap` is registered. It is high in the cycle after the edge at which `count` == 0 followed all-ones, for exactly one cycle.
- `overflow` and `step_err` rise in the cycle after the offending edge.
- The first sample after reset never produces a wrap or a step error.

## Configuration
- `COUNT_SNAPSHOT_STEP_CHECK_EN`:
  - When defined, the step checker is compiled in. `step_err` is set when `prev_valid` && `count` != `count_q` + 1 (mod 2^CNT_W).
  - When undefined, no checker logic exists and `step_err` is tied to 0.

## Structure
- Package `count_snapshot_pkg` holds:
  - default widths `CNT_W_D`, `EPOCH_W_D`, `DEPTH_D`;
  - typedef `snap_entry_t` as a packed struct {epoch, count};
  - a `clog2`-based level-width constant.
- Sub-module `count_snapshot_fifo` is a parameterised first-word-fall-through FIFO. It has push, pop, full, empty and level ports and is instantiated once.
- Wrap detection, the epoch counter, the step checker and the sticky flags live in the top module.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `cap_req` = 1. All outputs must be 0 and `fifo_level` = 0 after release.
- Wrap: drive `count` 0..15 then 0. `wrap` must be high for exactly 1 cycle, the cycle after 0 is sampled. A later capture must report epoch 1.
- Single capture: `cap_req` at `count` = 5, epoch 0, `snap_ready` = 0. Next cycle `snap_valid` = 1, `snap_data` = 12'h005, `fifo_level` = 1.
- Overflow and drain: 5 captures at counts 1..5 with `snap_ready` = 0.
  - Expected: `fifo_level` = 4, `overflow` = 1.
  - Then set `snap_ready` = 1: data 12'h001..12'h004 drain in order, `snap_valid` drops after 4 pops.
- Simultaneous wrap and capture: `count` 15→0 with `cap_req` in the cycle where `count` = 0, epoch previously 0. `snap_data` must be 12'h010.
- Step error: `count` jumps 3→7.
  - Macro defined: `step_err` = 1 the next cycle and stays 1 until reset.
  - Macro undefined: `step_err` stays 0.
